fir_complex_decim: RTL and testbench
====================================

# fir_complex_decim

Parametrised complex-coefficient FIR with integer decimation and a runtime-loadable coefficient bank, for the FM radio channel-filter stage. Consumes paired I/Q samples from two input FIFOs and produces one filtered complex sample per DECIM inputs into two output FIFOs. The MAC is time-multiplexed over UNROLL lanes. It replaces the fixed-tap, decimate-by-one complex filter in the front end.

## Interface
- DATA_SIZE, 32: sample and coefficient width, signed two's complement.
- TAPS, 20: filter length; must be a multiple of UNROLL.
- UNROLL, 4: taps processed per MAC cycle.
- DECIM, 1: input samples consumed per output sample; must be ≥1.
- BITS, 10: dequantisation shift (fixed-point fraction bits).

- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- i_in / q_in  in  DATA_SIZE  input FIFO read data, first-word-fall-through.
- i_empty / q_empty  in  1  input FIFO empty flags.
- i_rd_en / q_rd_en  out  1  input FIFO pops; always asserted together.
- coef_wr_en  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index.
- coef_real_din / coef_imag_din  in  DATA_SIZE  coefficient value.
- coef_ready  out  1  high when coefficient writes are accepted.
- real_dout / imag_dout  out  DATA_SIZE  output sample.
- real_wr_en / imag_wr_en  out  1  output FIFO pushes; always asserted together.
- real_full / imag_full  in  1  output FIFO full flags.

## Operation
- Convolution: history[0] is the newest sample. y_r = Σ_k deq(hr[k]·xr[k]) − deq(hi[k]·xi[k]) and y_i = Σ_k deq(hr[k]·xi[k]) + deq(hi[k]·xr[k]).
- deq(p): compute the full 2·DATA_SIZE signed product, arithmetic-shift it right by BITS, then keep the low DATA_SIZE bits. Accumulate in DATA_SIZE bits with wrap-around (no saturation).
- FSM states:
  - S_LOAD: when i_empty=0 and q_empty=0, assert both rd_en combinationally in the same cycle. Shift the history right by one, insert (i_in, q_in) at index 0, and increment the load count. When the load count reaches DECIM, clear it and go to S_MAC.
  - S_MAC: clear both accumulators on entry. Each cycle add the UNROLL terms for taps m·UNROLL..m·UNROLL+UNROLL−1. After TAPS/UNROLL cycles go to S_OUT.
  - S_OUT: when real_full=0 and imag_full=0, assert both wr_en for one cycle with the accumulator values on the dout ports, then go to S_LOAD. Otherwise hold in S_OUT with dout stable.
- Only one input is consumed per cycle. If exactly one input FIFO is non-empty, nothing is popped.
- coef_ready = (state == S_LOAD) and (load count == 0).
- A write with coef_wr_en=1 and coef_ready=1 updates bank[coef_addr] on the next edge. Writes while coef_ready=0, or with coef_addr ≥ TAPS, are silently dropped.
- Reset values: state S_LOAD, load count 0, history all zero, coefficient bank all zero, accumulators zero. All rd_en/wr_en = 0, real_dout = imag_dout = 0, coef_ready = 1 in the first cycle after reset.
- Reset asserted in any state, including mid-MAC or while stalled in S_OUT, aborts the pending output; no wr_en is issued.

## Timing
- Input acceptance: at most 1 sample pair per cycle.
- Latency: from the edge that pops the DECIM-th sample, the FSM spends TAPS/UNROLL cycles in S_MAC. wr_en asserts in the next cycle if the outputs are not full. With the defaults this is 5 S_MAC cycles, so wr_en asserts in cycle 6.
- Minimum throughput period: DECIM + TAPS/UNROLL + 1 cycles per output.
- Both wr_en pulses are exactly one cycle per output, never duplicated. dout is valid only while wr_en=1.
- If full deasserts in the same cycle the FSM enters S_OUT, the write occurs in that cycle.

## Test plan
- Impulse, DECIM=1, TAPS=20, UNROLL=4, BITS=10, hr[k]=1024·(k+1), hi=0. Drive I=1024 then 24 zeros, Q=0 → real_dout sequence 1024, 2048, …, 20480, then 0×5. imag_dout is all 0. Exactly 25 writes.
- Rotation: hr[0]=0, hi[0]=1024, all other taps 0. Drive input (100, 200) → output (−200, 100). Drive (−7, 3) → (−3, −7).
- Decimation DECIM=4, TAPS=8, UNROLL=4, hr[k]=1024, hi=0. Drive constant I=1000, Q=−1000 → outputs after inputs 4, 8, 12 are (4000, −4000), (8000, −8000), (8000, −8000). rd_en is never high while in S_MAC or S_OUT.
- Backpressure/skew: hold real_full=1 at S_OUT → no wr_en, no further rd_en, dout stable. Release → exactly one write. Separately, hold q_empty=1 with i_empty=0 → i_rd_en and q_rd_en both stay 0.
- Coefficient gating: write during S_MAC, and write with coef_addr=TAPS → both dropped; the next output matches the old bank. Write with coef_ready=1 → used by the next output.
- Reset mid-S_MAC → no wr_en; a subsequent impulse gives all-zero output until coefficients are reloaded. coef_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/fir_complex_decim_if.sv
// Bus bundle for fir_complex_decim: paired I/Q input FIFO read side,
// coefficient write port and paired real/imag output FIFO write side.
interface fir_complex_decim_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 5
);
    // Input FIFOs (first-word-fall-through)
    logic [DATA_SIZE-1:0] i_in;
    logic [DATA_SIZE-1:0] q_in;
    logic                 i_empty;
    logic                 q_empty;
    logic                 i_rd_en;
    logic                 q_rd_en;

    // Coefficient bank write port
    logic                 coef_wr_en;
    logic [ADDR_W-1:0]    coef_addr;
    logic [DATA_SIZE-1:0] coef_real_din;
    logic [DATA_SIZE-1:0] coef_imag_din;
    logic                 coef_ready;

    // Output FIFOs
    logic [DATA_SIZE-1:0] real_dout;
    logic [DATA_SIZE-1:0] imag_dout;
    logic                 real_wr_en;
    logic                 imag_wr_en;
    logic                 real_full;
    logic                 imag_full;

    // Filter side
    modport slave (
        input  i_in, q_in, i_empty, q_empty,
        input  coef_wr_en, coef_addr, coef_real_din, coef_imag_din,
        input  real_full, imag_full,
        output i_rd_en, q_rd_en, coef_ready,
        output real_dout, imag_dout, real_wr_en, imag_wr_en
    );

    // Environment side (FIFOs and coefficient loader)
    modport master (
        output i_in, q_in, i_empty, q_empty,
        output coef_wr_en, coef_addr, coef_real_din, coef_imag_din,
        output real_full, imag_full,
        input  i_rd_en, q_rd_en, coef_ready,
        input  real_dout, imag_dout, real_wr_en, imag_wr_en
    );
endinterface

// File: rtl/fir_complex_decim.sv
// Complex-coefficient FIR with integer decimation and a runtime-loadable
// coefficient bank. Samples are shifted into a history line in S_LOAD, the
// convolution is evaluated UNROLL taps per cycle in S_MAC, and the result is
// pushed to the output FIFOs in S_OUT. Products are dequantised (shift by
// BITS) before being accumulated with wrap-around in DATA_SIZE bits.
module fir_complex_decim #(
    parameter int DATA_SIZE = 32,
    parameter int TAPS      = 20,
    parameter int UNROLL    = 4,
    parameter int DECIM     = 1,
    parameter int BITS      = 10
) (
    input  logic               clock,
    input  logic               reset,
    fir_complex_decim_if.slave bus
);
    localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int GROUPS = TAPS / UNROLL;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef logic [DATA_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [GRP_W-1:0]   mac_cnt_q, mac_cnt_d;
    word_t              acc_re_q, acc_re_d;
    word_t              acc_im_q, acc_im_d;
    word_t              hist_re_q [TAPS];
    word_t              hist_re_d [TAPS];
    word_t              hist_im_q [TAPS];
    word_t              hist_im_d [TAPS];
    word_t              coef_re_q [TAPS];
    word_t              coef_re_d [TAPS];
    word_t              coef_im_q [TAPS];
    word_t              coef_im_d [TAPS];

    logic               pop_s;
    logic               push_s;
    logic               coef_ready_s;
    logic               coef_wr_s;
    word_t              sum_re_s;
    word_t              sum_im_s;
    logic [ADDR_W-1:0]  tap_s;

    // Full-width signed product, arithmetic shift by BITS, keep the low word.
    function automatic word_t deq(input word_t a, input word_t b);
        logic signed [2*DATA_SIZE-1:0] p;
        p = $signed({{DATA_SIZE{a[DATA_SIZE-1]}}, a}) *
            $signed({{DATA_SIZE{b[DATA_SIZE-1]}}, b});
        p = p >>> BITS;
        return p[DATA_SIZE-1:0];
    endfunction

    // The bank may only change while idle in S_LOAD with no partial decimation group.
    assign coef_ready_s = (state_q == S_LOAD) && (load_cnt_q == '0);
    assign coef_wr_s    = bus.coef_wr_en && coef_ready_s && (int'(bus.coef_addr) < TAPS);

    assign bus.i_rd_en    = pop_s;
    assign bus.q_rd_en    = pop_s;
    assign bus.real_wr_en = push_s;
    assign bus.imag_wr_en = push_s;
    assign bus.real_dout  = acc_re_q;
    assign bus.imag_dout  = acc_im_q;
    assign bus.coef_ready = coef_ready_s;

    // Partial complex sum over the UNROLL taps selected by the MAC cycle counter.
    always_comb begin
        sum_re_s = '0;
        sum_im_s = '0;
        tap_s    = '0;
        for (int u = 0; u < UNROLL; u++) begin
            tap_s    = ADDR_W'(int'(mac_cnt_q) * UNROLL + u);
            sum_re_s = sum_re_s + deq(coef_re_q[tap_s], hist_re_q[tap_s])
                                - deq(coef_im_q[tap_s], hist_im_q[tap_s]);
            sum_im_s = sum_im_s + deq(coef_re_q[tap_s], hist_im_q[tap_s])
                                + deq(coef_im_q[tap_s], hist_re_q[tap_s]);
        end
    end

    // Next-state, history shift, accumulation and FIFO handshakes.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        mac_cnt_d  = mac_cnt_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        hist_re_d  = hist_re_q;
        hist_im_d  = hist_im_q;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        case (state_q)
            S_LOAD: begin
                // Both FIFOs must hold data; a one-sided sample is left in place.
                if (!bus.i_empty && !bus.q_empty) begin
                    pop_s = 1'b1;
                    for (int k = TAPS - 1; k > 0; k--) begin
                        hist_re_d[k] = hist_re_q[k-1];
                        hist_im_d[k] = hist_im_q[k-1];
                    end
                    hist_re_d[0] = bus.i_in;
                    hist_im_d[0] = bus.q_in;
                    if (int'(load_cnt_q) == DECIM - 1) begin
                        load_cnt_d = '0;
                        mac_cnt_d  = '0;
                        state_d    = S_MAC;
                    end else begin
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            S_MAC: begin
                // The first MAC cycle starts from zero instead of the old result.
                if (mac_cnt_q == '0) begin
                    acc_re_d = sum_re_s;
                    acc_im_d = sum_im_s;
                end else begin
                    acc_re_d = acc_re_q + sum_re_s;
                    acc_im_d = acc_im_q + sum_im_s;
                end
                if (int'(mac_cnt_q) == GROUPS - 1) begin
                    mac_cnt_d = '0;
                    state_d   = S_OUT;
                end else begin
                    mac_cnt_d = mac_cnt_q + GRP_W'(1);
                end
            end
            S_OUT: begin
                // Hold the result on dout until both output FIFOs have room.
                if (!bus.real_full && !bus.imag_full) begin
                    push_s  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    push_s  = 1'b0;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Coefficient bank update; gated and out-of-range writes are discarded.
    always_comb begin
        coef_re_d = coef_re_q;
        coef_im_d = coef_im_q;
        if (coef_wr_s) begin
            coef_re_d[bus.coef_addr] = bus.coef_real_din;
            coef_im_d[bus.coef_addr] = bus.coef_imag_din;
        end else begin
            coef_re_d = coef_re_q;
            coef_im_d = coef_im_q;
        end
    end

    // State registers with synchronous reset; reset discards any pending output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            mac_cnt_q  <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                hist_re_q[k] <= '0;
                hist_im_q[k] <= '0;
                coef_re_q[k] <= '0;
                coef_im_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            mac_cnt_q  <= mac_cnt_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            hist_re_q  <= hist_re_d;
            hist_im_q  <= hist_im_d;
            coef_re_q  <= coef_re_d;
            coef_im_q  <= coef_im_d;
        end
    end
endmodule

// File: tb/tb_fir_complex_decim.sv
// Bench for fir_complex_decim: instance A uses the default configuration
// (TAPS=20, UNROLL=4, DECIM=1), instance B a decimating one (TAPS=8, DECIM=4).
// Expected outputs come from a direct convolution over the input history.
module tb_fir_complex_decim;
    localparam int DW       = 32;
    localparam int BITS     = 10;
    localparam int A_TAPS   = 20;
    localparam int A_UNROLL = 4;
    localparam int A_DECIM  = 1;
    localparam int A_AW     = $clog2(A_TAPS);
    localparam int B_TAPS   = 8;
    localparam int B_UNROLL = 4;
    localparam int B_DECIM  = 4;
    localparam int B_AW     = $clog2(B_TAPS);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fir_complex_decim_if #(.DATA_SIZE(DW), .ADDR_W(A_AW)) ifa ();
    fir_complex_decim_if #(.DATA_SIZE(DW), .ADDR_W(B_AW)) ifb ();

    fir_complex_decim #(.DATA_SIZE(DW), .TAPS(A_TAPS), .UNROLL(A_UNROLL), .DECIM(A_DECIM), .BITS(BITS))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));
    fir_complex_decim #(.DATA_SIZE(DW), .TAPS(B_TAPS), .UNROLL(B_UNROLL), .DECIM(B_DECIM), .BITS(BITS))
        dut_b (.clock(clock), .reset(reset), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A environment and model
    int   a_src_i[$], a_src_q[$], a_hist_i[$], a_hist_q[$];
    int   a_exp_r[$], a_exp_i[$], a_out_r[$], a_out_i[$];
    int   a_hr[A_TAPS], a_hi[A_TAPS];
    int   a_fed = 0, a_pops = 0, a_pair_err = 0;
    bit   a_pop = 1'b0, a_hold_q_empty = 1'b0, a_hold_full = 1'b0;
    logic a_ready_seen, a_last_rd, a_last_wr;
    int   a_last_dr, a_last_di;

    // Instance B environment and model
    int   b_src_i[$], b_src_q[$], b_hist_i[$], b_hist_q[$];
    int   b_exp_r[$], b_exp_i[$], b_out_r[$], b_out_i[$];
    int   b_hr[B_TAPS], b_hi[B_TAPS];
    int   b_fed = 0, b_pops = 0, b_pair_err = 0, b_rd_busy_err = 0;
    bit   b_pop = 1'b0, b_busy = 1'b0;
    logic b_ready_seen;

    function automatic int deq(input int c, input int x);
        longint p;
        p = longint'(c) * longint'(x);
        p = p >>> BITS;
        return int'(p);
    endfunction

    task automatic drive_inputs();
        ifa.i_empty   = (a_src_i.size() == 0);
        ifa.q_empty   = (a_src_q.size() == 0) || a_hold_q_empty;
        ifa.i_in      = (a_src_i.size() > 0) ? a_src_i[0] : 0;
        ifa.q_in      = (a_src_q.size() > 0) ? a_src_q[0] : 0;
        ifa.real_full = a_hold_full;
        ifa.imag_full = a_hold_full;
        ifb.i_empty   = (b_src_i.size() == 0);
        ifb.q_empty   = (b_src_q.size() == 0);
        ifb.i_in      = (b_src_i.size() > 0) ? b_src_i[0] : 0;
        ifb.q_in      = (b_src_q.size() > 0) ? b_src_q[0] : 0;
        ifb.real_full = 1'b0;
        ifb.imag_full = 1'b0;
    endtask

    // One clock: observe both DUTs mid-cycle, then apply FIFO pops after the edge.
    task automatic tick();
        @(negedge clock);
        a_pop        = (ifa.i_rd_en === 1'b1);
        a_ready_seen = ifa.coef_ready;
        a_last_rd    = ifa.i_rd_en;
        a_last_wr    = ifa.real_wr_en;
        a_last_dr    = int'(ifa.real_dout);
        a_last_di    = int'(ifa.imag_dout);
        if ((ifa.i_rd_en !== ifa.q_rd_en) || (ifa.real_wr_en !== ifa.imag_wr_en)) a_pair_err++;
        if (a_pop) a_pops++;
        if (ifa.real_wr_en === 1'b1) begin
            a_out_r.push_back(int'(ifa.real_dout));
            a_out_i.push_back(int'(ifa.imag_dout));
        end
        b_pop        = (ifb.i_rd_en === 1'b1);
        b_ready_seen = ifb.coef_ready;
        if ((ifb.i_rd_en !== ifb.q_rd_en) || (ifb.real_wr_en !== ifb.imag_wr_en)) b_pair_err++;
        if (b_busy && b_pop) b_rd_busy_err++;
        if (ifb.real_wr_en === 1'b1) begin
            b_out_r.push_back(int'(ifb.real_dout));
            b_out_i.push_back(int'(ifb.imag_dout));
            b_busy = 1'b0;
        end
        if (b_pop) begin
            b_pops++;
            if (b_pops % B_DECIM == 0) b_busy = 1'b1;
        end
        @(posedge clock);
        #1;
        if (a_pop && a_src_i.size() > 0) begin
            void'(a_src_i.pop_front());
            void'(a_src_q.pop_front());
        end
        if (b_pop && b_src_i.size() > 0) begin
            void'(b_src_i.pop_front());
            void'(b_src_q.pop_front());
        end
        drive_inputs();
    endtask

    task automatic feed_a(input int xi, input int xq);
        int yr, yi;
        a_src_i.push_back(xi);
        a_src_q.push_back(xq);
        a_hist_i.push_front(xi);
        a_hist_q.push_front(xq);
        if (a_hist_i.size() > A_TAPS) begin
            void'(a_hist_i.pop_back());
            void'(a_hist_q.pop_back());
        end
        a_fed++;
        if (a_fed % A_DECIM == 0) begin
            yr = 0;
            yi = 0;
            for (int k = 0; k < a_hist_i.size(); k++) begin
                yr += deq(a_hr[k], a_hist_i[k]) - deq(a_hi[k], a_hist_q[k]);
                yi += deq(a_hr[k], a_hist_q[k]) + deq(a_hi[k], a_hist_i[k]);
            end
            a_exp_r.push_back(yr);
            a_exp_i.push_back(yi);
        end
        drive_inputs();
    endtask

    task automatic feed_b(input int xi, input int xq);
        int yr, yi;
        b_src_i.push_back(xi);
        b_src_q.push_back(xq);
        b_hist_i.push_front(xi);
        b_hist_q.push_front(xq);
        if (b_hist_i.size() > B_TAPS) begin
            void'(b_hist_i.pop_back());
            void'(b_hist_q.pop_back());
        end
        b_fed++;
        if (b_fed % B_DECIM == 0) begin
            yr = 0;
            yi = 0;
            for (int k = 0; k < b_hist_i.size(); k++) begin
                yr += deq(b_hr[k], b_hist_i[k]) - deq(b_hi[k], b_hist_q[k]);
                yi += deq(b_hr[k], b_hist_q[k]) + deq(b_hi[k], b_hist_i[k]);
            end
            b_exp_r.push_back(yr);
            b_exp_i.push_back(yi);
        end
        drive_inputs();
    endtask

    // Write one coefficient pair to A for one cycle.
    task automatic write_a(input int addr, input int re, input int im);
        ifa.coef_wr_en    = 1'b1;
        ifa.coef_addr     = A_AW'(addr);
        ifa.coef_real_din = re;
        ifa.coef_imag_din = im;
        tick();
        ifa.coef_wr_en    = 1'b0;
    endtask

    // Copy the whole model bank of A into the DUT.
    task automatic sync_bank_a();
        for (int k = 0; k < A_TAPS; k++) write_a(k, a_hr[k], a_hi[k]);
    endtask

    task automatic sync_bank_b();
        for (int k = 0; k < B_TAPS; k++) begin
            ifb.coef_wr_en    = 1'b1;
            ifb.coef_addr     = B_AW'(k);
            ifb.coef_real_din = b_hr[k];
            ifb.coef_imag_din = b_hi[k];
            tick();
        end
        ifb.coef_wr_en = 1'b0;
    endtask

    task automatic drain_a(input string name, input int budget);
        int cyc, n;
        cyc = 0;
        while ((a_out_r.size() < a_exp_r.size() || a_src_i.size() != 0) && cyc < budget) begin
            tick();
            cyc++;
        end
        repeat (12) tick();
        n_checks++;
        if (a_out_r.size() !== a_exp_r.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, a_out_r.size(), a_exp_r.size());
        end
        n = (a_out_r.size() < a_exp_r.size()) ? a_out_r.size() : a_exp_r.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if ((a_out_r[i] !== a_exp_r[i]) || (a_out_i[i] !== a_exp_i[i])) begin
                n_fail++;
                $display("FAIL %s[%0d]: got (%0d,%0d) expected (%0d,%0d)", name, i,
                         a_out_r[i], a_out_i[i], a_exp_r[i], a_exp_i[i]);
            end
        end
        a_out_r.delete(); a_out_i.delete(); a_exp_r.delete(); a_exp_i.delete();
    endtask

    task automatic drain_b(input string name, input int budget);
        int cyc, n;
        cyc = 0;
        while ((b_out_r.size() < b_exp_r.size() || b_src_i.size() != 0) && cyc < budget) begin
            tick();
            cyc++;
        end
        repeat (12) tick();
        n_checks++;
        if (b_out_r.size() !== b_exp_r.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes expected %0d", name, b_out_r.size(), b_exp_r.size());
        end
        n = (b_out_r.size() < b_exp_r.size()) ? b_out_r.size() : b_exp_r.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if ((b_out_r[i] !== b_exp_r[i]) || (b_out_i[i] !== b_exp_i[i])) begin
                n_fail++;
                $display("FAIL %s[%0d]: got (%0d,%0d) expected (%0d,%0d)", name, i,
                         b_out_r[i], b_out_i[i], b_exp_r[i], b_exp_i[i]);
            end
        end
        b_out_r.delete(); b_out_i.delete(); b_exp_r.delete(); b_exp_i.delete();
    endtask

    task automatic clear_models();
        a_src_i.delete(); a_src_q.delete(); a_hist_i.delete(); a_hist_q.delete();
        a_exp_r.delete(); a_exp_i.delete(); a_out_r.delete(); a_out_i.delete();
        b_src_i.delete(); b_src_q.delete(); b_hist_i.delete(); b_hist_q.delete();
        b_exp_r.delete(); b_exp_i.delete(); b_out_r.delete(); b_out_i.delete();
        for (int k = 0; k < A_TAPS; k++) begin a_hr[k] = 0; a_hi[k] = 0; end
        for (int k = 0; k < B_TAPS; k++) begin b_hr[k] = 0; b_hi[k] = 0; end
        a_fed = 0; b_fed = 0; b_pops = 0; b_busy = 1'b0;
        drive_inputs();
    endtask

    task automatic test_reset();
        tick();
        n_checks++;
        if (a_ready_seen !== 1'b1 || b_ready_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_coef_ready: got %b/%b expected 1/1", a_ready_seen, b_ready_seen);
        end
        n_checks++;
        if (a_last_rd !== 1'b0 || a_last_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_enables: got rd=%b wr=%b expected 0/0", a_last_rd, a_last_wr);
        end
        n_checks++;
        if (a_last_dr !== 0 || a_last_di !== 0) begin
            n_fail++;
            $display("FAIL reset_dout: got (%0d,%0d) expected (0,0)", a_last_dr, a_last_di);
        end
    endtask

    task automatic test_impulse();
        for (int k = 0; k < A_TAPS; k++) begin a_hr[k] = 1024 * (k + 1); a_hi[k] = 0; end
        sync_bank_a();
        n_checks++;
        if (a_ready_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_coef_ready: got %b expected 1", a_ready_seen);
        end
        feed_a(1024, 0);
        for (int n = 0; n < 24; n++) feed_a(0, 0);
        drain_a("impulse", 2000);
    endtask

    task automatic test_rotation();
        for (int k = 0; k < A_TAPS; k++) begin a_hr[k] = 0; a_hi[k] = 0; end
        a_hi[0] = 1024;
        sync_bank_a();
        feed_a(100, 200);
        feed_a(-7, 3);
        drain_a("rotation", 200);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < A_TAPS; k++) begin
            a_hr[k] = (k % 3 == 0) ? int'($urandom()) : int'($urandom_range(0, 8191)) - 4096;
            a_hi[k] = (k % 4 == 1) ? int'($urandom()) : int'($urandom_range(0, 8191)) - 4096;
        end
        sync_bank_a();
        for (int n = 0; n < 30; n++) begin
            if (n % 5 == 0) feed_a(int'($urandom()), int'($urandom()));
            else feed_a(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        end
        drain_a("random", 2000);
        n_checks++;
        if (a_pair_err !== 0) begin
            n_fail++;
            $display("FAIL a_enable_pairing: got %0d unpaired cycles expected 0", a_pair_err);
        end
    endtask

    task automatic test_backpressure();
        int p0, stable_err, ref_r, ref_i, n_wr;
        a_hold_full = 1'b1;
        drive_inputs();
        p0 = a_pops;
        for (int n = 0; n < 3; n++) feed_a(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
        stable_err = 0;
        ref_r = 0;
        ref_i = 0;
        n_wr = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a_last_wr === 1'b1) n_wr++;
            if (c == 15) begin
                ref_r = a_last_dr;
                ref_i = a_last_di;
            end else if (c > 15 && (a_last_dr !== ref_r || a_last_di !== ref_i)) begin
                stable_err++;
            end
        end
        n_checks++;
        if (n_wr !== 0) begin
            n_fail++;
            $display("FAIL stall_no_write: got %0d writes expected 0", n_wr);
        end
        n_checks++;
        if (a_pops - p0 !== 1) begin
            n_fail++;
            $display("FAIL stall_no_read: got %0d pops expected 1", a_pops - p0);
        end
        n_checks++;
        if (stable_err !== 0) begin
            n_fail++;
            $display("FAIL stall_dout_stable: got %0d changes expected 0", stable_err);
        end
        a_hold_full = 1'b0;
        drive_inputs();
        tick();
        n_checks++;
        if (a_out_r.size() !== 1) begin
            n_fail++;
            $display("FAIL release_one_write: got %0d writes expected 1", a_out_r.size());
        end
        drain_a("backpressure", 200);

        a_hold_q_empty = 1'b1;
        drive_inputs();
        p0 = a_pops;
        feed_a(55, -66);
        repeat (10) tick();
        n_checks++;
        if (a_pops - p0 !== 0 || a_src_i.size() !== 1) begin
            n_fail++;
            $display("FAIL skew_no_pop: got %0d pops expected 0", a_pops - p0);
        end
        a_hold_q_empty = 1'b0;
        drive_inputs();
        drain_a("skew", 200);
    endtask

    task automatic test_coef_gating();
        int cyc;
        for (int k = 0; k < A_TAPS; k++) begin
            a_hr[k] = int'($urandom_range(0, 4095)) - 2048;
            a_hi[k] = int'($urandom_range(0, 4095)) - 2048;
        end
        sync_bank_a();
        feed_a(1234, -567);
        cyc = 0;
        do begin tick(); cyc++; end while (!a_pop && cyc < 20);
        write_a(0, 32'h0001_0000, 32'h0002_0000);
        n_checks++;
        if (a_ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mac_coef_ready: got %b expected 0", a_ready_seen);
        end
        drain_a("gate_mac_write", 200);
        write_a(A_TAPS, 32'h0003_0000, 32'h0004_0000);
        feed_a(-321, 789);
        drain_a("gate_bad_addr", 200);
        a_hr[1] = 5000;
        a_hi[1] = -3000;
        write_a(1, a_hr[1], a_hi[1]);
        feed_a(2048, 1024);
        drain_a("gate_accepted", 200);
    endtask

    task automatic test_decim();
        int cyc;
        for (int k = 0; k < B_TAPS; k++) begin b_hr[k] = 1024; b_hi[k] = 0; end
        sync_bank_b();
        feed_b(1000, -1000);
        cyc = 0;
        do begin tick(); cyc++; end while (!b_pop && cyc < 20);
        tick();
        n_checks++;
        if (b_ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL decim_partial_ready: got %b expected 0", b_ready_seen);
        end
        for (int n = 1; n < 12; n++) feed_b(1000, -1000);
        drain_b("decim", 1000);
        n_checks++;
        if (b_rd_busy_err !== 0 || b_pair_err !== 0) begin
            n_fail++;
            $display("FAIL decim_rd_while_busy: got %0d/%0d expected 0/0", b_rd_busy_err, b_pair_err);
        end
    endtask

    task automatic test_reset_mid_mac();
        int cyc, n_wr;
        feed_a(777, 888);
        cyc = 0;
        do begin tick(); cyc++; end while (!a_pop && cyc < 20);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_models();
        tick();
        n_checks++;
        if (a_ready_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b expected 1", a_ready_seen);
        end
        n_wr = (a_last_wr === 1'b1) ? 1 : 0;
        repeat (12) begin
            tick();
            if (a_last_wr === 1'b1) n_wr++;
        end
        n_checks++;
        if (n_wr !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_write: got %0d writes expected 0", n_wr);
        end
        feed_a(1024, 0);
        for (int n = 0; n < 4; n++) feed_a(0, 0);
        drain_a("post_reset_impulse", 500);
    endtask

    initial begin
        ifa.coef_wr_en = 1'b0; ifa.coef_addr = '0; ifa.coef_real_din = '0; ifa.coef_imag_din = '0;
        ifb.coef_wr_en = 1'b0; ifb.coef_addr = '0; ifb.coef_real_din = '0; ifb.coef_imag_din = '0;
        clear_models();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        test_reset();
        test_impulse();
        test_rotation();
        test_back_to_back();
        test_backpressure();
        test_coef_gating();
        test_decim();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
